ex_mem_reg: RTL and testbench
=============================

# ex_mem_reg

EX/MEM pipeline register of the five-stage MIPS core: captures the EX stage's register-file write request and HI/LO write request on each clock and presents them to the MEM stage. It applies the pipeline stall/flush rules, inserting a bubble when EX stalls while MEM proceeds. It also holds the 64-bit partial result and cycle count that EX feeds back during two-cycle MADD/MADDU/MSUB/MSUBU.

## Interface
Parameters:
- DATA_W, 32, general register / HI / LO width
- ADDR_W, 5, register-file address width
- STALL_W, 6, stall vector width (bit 0 = PC … bit 5 = WB)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- stall  in  STALL_W  per-stage stall from control; bit 3 = EX, bit 4 = MEM
- flush  in  1  exception flush; clears the stage
- ex_wd  in  ADDR_W  destination register from EX
- ex_wreg  in  1  register write enable from EX
- ex_wdata  in  DATA_W  register write data from EX
- ex_whilo  in  1  HI/LO write enable from EX
- ex_hi, ex_lo  in  DATA_W each  HI/LO write data from EX
- hilo_i  in  2*DATA_W  partial MADD/MSUB product from EX
- cnt_i  in  2  MADD/MSUB cycle count from EX
- mem_wd  out  ADDR_W  to MEM stage
- mem_wreg  out  1  to MEM stage
- mem_wdata  out  DATA_W  to MEM stage
- mem_whilo  out  1  to MEM stage
- mem_hi, mem_lo  out  DATA_W each  to MEM stage
- hilo_o  out  2*DATA_W  registered partial product back to EX
- cnt_o  out  2  registered cycle count back to EX

## Operation
- All outputs are registers; no combinational path from inputs to outputs.
- Priority per rising edge, highest first:
  1. flush = 1: all stage outputs to NOP (mem_wd = 0, mem_wreg = 0, mem_wdata = 0, mem_whilo = 0, mem_hi = mem_lo = 0); hilo_o = 0, cnt_o = 0.
  2. stall[3] = 1 and stall[4] = 0: EX stalled, MEM free, so insert a bubble. Stage outputs go to NOP as in flush. hilo_o <= hilo_i and cnt_o <= cnt_i, so the first MADD cycle's partial product survives.
  3. stall[3] = 0: normal advance. All mem_* outputs capture the matching ex_* inputs. hilo_o <= 0 and cnt_o <= 0, because the multi-cycle op has completed or never started.
  4. stall[3] = 1 and stall[4] = 1: hold. Every register keeps its value.
- Illegal stall pattern stall[3] = 0 with stall[4] = 1 is treated per rule 3 (advance). Control never generates it; an assertion flags it in simulation.
- Bits of stall other than 3 and 4 are ignored.
- No arithmetic is performed; widths pass through unchanged.

## Timing
- Reset (rst = 0, asynchronous, independent of clk): all outputs 0 immediately and held while rst = 0.
- First capture occurs on the first rising edge after rst deasserts.
- Latency: 1 cycle from ex_* to mem_*.
- hilo_o / cnt_o are valid to EX one cycle after the cycle in which EX drove them while stalled.
- MADD sequence, as seen here:
  - Cycle N: EX drives cnt_i = 1 and hilo_i = product, and asserts stall[3].
  - Edge N+1: hilo_o/cnt_o latch; MEM sees a bubble.
  - Cycle N+1: EX consumes hilo_o, drives the final ex_hi/ex_lo, and releases the stall.
  - Edge N+2: results captured into mem_*; hilo_o/cnt_o cleared.
- Flush asserted in the same cycle as any stall pattern wins; it also discards a pending MADD partial.
- rst asserted mid-sequence clears the partial product and count; no recovery.

## Test plan
- Reset: rst = 0 with all inputs 0xFFFFFFFF / 1 → every output 0 with no clock edge; rst = 1 then one edge → mem_wdata = 0xFFFFFFFF, mem_wd = 31.
- Advance: stall = 0, ex_wd = 5, ex_wreg = 1, ex_wdata = 0x12345678 → next cycle mem_wd = 5, mem_wreg = 1, mem_wdata = 0x12345678; hilo_o = 0.
- Bubble: stall = 6'b001111, ex_wreg = 1, hilo_i = 0x0000_0001_FFFF_FFFE, cnt_i = 1 → mem_wreg = 0, mem_wd = 0, hilo_o = 0x0000_0001_FFFF_FFFE, cnt_o = 1.
- Hold: prior mem_wdata = 0xA5A5A5A5, stall = 6'b011111, inputs changed → mem_wdata stays 0xA5A5A5A5 and hilo_o unchanged for 3 cycles.
- MADD two-cycle: bubble cycle as above, then stall = 0, ex_whilo = 1, ex_hi = 2, ex_lo = 3 → mem_whilo = 1, mem_hi = 2, mem_lo = 3, hilo_o = 0, cnt_o = 0.
- Flush priority: flush = 1 with stall = 6'b001111 and hilo_i nonzero → all outputs 0, including hilo_o and cnt_o.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: forwards EX write requests to MEM and keeps the
// MADD/MSUB partial product and cycle count that EX feeds back to itself.
module ex_mem_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic                ex_whilo,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [1:0]          cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_whilo,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [1:0]          cnt_o
);

    logic ex_stall;
    logic mem_stall;
    logic unused_stall_bits;

    assign ex_stall          = stall[3];
    assign mem_stall         = stall[4];
    assign unused_stall_bits = ^{stall[STALL_W-1:5], stall[2:0]};

    // EX -> MEM stage boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_whilo <= 1'b0;
            mem_hi    <= '0;
            mem_lo    <= '0;
            hilo_o    <= '0;
            cnt_o     <= '0;
        end else if (flush) begin
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_whilo <= 1'b0;
            mem_hi    <= '0;
            mem_lo    <= '0;
            hilo_o    <= '0;
            cnt_o     <= '0;
        end else if (ex_stall && !mem_stall) begin
            // Bubble to MEM while the first MADD cycle's partial is kept for EX
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_whilo <= 1'b0;
            mem_hi    <= '0;
            mem_lo    <= '0;
            hilo_o    <= hilo_i;
            cnt_o     <= cnt_i;
        end else if (!ex_stall) begin
            mem_wd    <= ex_wd;
            mem_wreg  <= ex_wreg;
            mem_wdata <= ex_wdata;
            mem_whilo <= ex_whilo;
            mem_hi    <= ex_hi;
            mem_lo    <= ex_lo;
            hilo_o    <= '0;
            cnt_o     <= '0;
        end
    end

    // MEM stalled while EX runs would drop an instruction; control must never do this.
    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            assert (!(mem_stall && !ex_stall))
                else $error("ex_mem_reg: illegal stall pattern %b", stall);
        end
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: reset, advance, bubble, hold, MADD, flush.
module tb_ex_mem_reg;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int total = 0;
    int bad   = 0;

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stage_zero(input string tag);
        chk({tag, ".wd"},    64'(mem_wd),    64'd0);
        chk({tag, ".wreg"},  64'(mem_wreg),  64'd0);
        chk({tag, ".wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, ".whilo"}, 64'(mem_whilo), 64'd0);
        chk({tag, ".hi"},    64'(mem_hi),    64'd0);
        chk({tag, ".lo"},    64'(mem_lo),    64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        stall    = 6'h3f;
        flush    = 1'b1;
        ex_wd    = 5'd31;
        ex_wreg  = 1'b1;
        ex_wdata = 32'hFFFF_FFFF;
        ex_whilo = 1'b1;
        ex_hi    = 32'hFFFF_FFFF;
        ex_lo    = 32'hFFFF_FFFF;
        hilo_i   = 64'hFFFF_FFFF_FFFF_FFFF;
        cnt_i    = 2'd3;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b0;
        #1;
        chk_stage_zero("reset_async");
        chk("reset_async.hilo", hilo_o, 64'd0);
        chk("reset_async.cnt",  64'(cnt_o), 64'd0);

        // Edge while still in reset keeps everything at zero
        stall = 6'd0;
        flush = 1'b0;
        step();
        chk("reset_held.wdata", 64'(mem_wdata), 64'd0);

        // First capture after release
        rst = 1'b1;
        step();
        chk("reset_rel.wdata", 64'(mem_wdata), 64'hFFFF_FFFF);
        chk("reset_rel.wd",    64'(mem_wd),    64'd31);
        chk("reset_rel.hilo",  hilo_o,         64'd0);

        // Normal advance
        ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
        ex_whilo = 1'b0; ex_hi = 32'd0; ex_lo = 32'd0;
        hilo_i = 64'h0000_0000_DEAD_BEEF; cnt_i = 2'd2;
        step();
        chk("adv.wd",    64'(mem_wd),    64'd5);
        chk("adv.wreg",  64'(mem_wreg),  64'd1);
        chk("adv.wdata", 64'(mem_wdata), 64'h1234_5678);
        chk("adv.hilo",  hilo_o,         64'd0);
        chk("adv.cnt",   64'(cnt_o),     64'd0);

        // Bubble: EX stalled, MEM free -- first MADD cycle
        stall = 6'b001111; ex_wreg = 1'b1;
        hilo_i = 64'h0000_0001_FFFF_FFFE; cnt_i = 2'd1;
        step();
        chk_stage_zero("bubble");
        chk("bubble.hilo", hilo_o,     64'h0000_0001_FFFF_FFFE);
        chk("bubble.cnt",  64'(cnt_o), 64'd1);

        // Second MADD cycle: stall released, final HI/LO delivered
        stall = 6'd0; ex_whilo = 1'b1; ex_hi = 32'd2; ex_lo = 32'd3;
        ex_wreg = 1'b0; ex_wd = 5'd0; ex_wdata = 32'd0;
        step();
        chk("madd.whilo", 64'(mem_whilo), 64'd1);
        chk("madd.hi",    64'(mem_hi),    64'd2);
        chk("madd.lo",    64'(mem_lo),    64'd3);
        chk("madd.hilo",  hilo_o,         64'd0);
        chk("madd.cnt",   64'(cnt_o),     64'd0);

        // Load A5A5A5A5 then hold for three cycles with changing inputs
        ex_whilo = 1'b0; ex_wreg = 1'b1; ex_wd = 5'd9; ex_wdata = 32'hA5A5_A5A5;
        step();
        chk("pre_hold.wdata", 64'(mem_wdata), 64'hA5A5_A5A5);
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            ex_wdata = 32'h1111_0000 + 32'(i);
            ex_wd    = 5'(i + 1);
            hilo_i   = 64'h77 + 64'(i);
            cnt_i    = 2'd1;
            step();
            chk("hold.wdata", 64'(mem_wdata), 64'hA5A5_A5A5);
            chk("hold.wd",    64'(mem_wd),    64'd9);
            chk("hold.hilo",  hilo_o,         64'd0);
        end

        // Bubble then hold keeps a nonzero partial product
        stall = 6'b001111; hilo_i = 64'h0123_4567_89AB_CDEF; cnt_i = 2'd1;
        step();
        chk("bubble2.hilo", hilo_o, 64'h0123_4567_89AB_CDEF);
        stall = 6'b011111; hilo_i = 64'd0; cnt_i = 2'd0;
        step();
        chk("hold2.hilo",  hilo_o,     64'h0123_4567_89AB_CDEF);
        chk("hold2.cnt",   64'(cnt_o), 64'd1);
        chk("hold2.wdata", 64'(mem_wdata), 64'd0);

        // Stall bits other than 3 and 4 are ignored (advance)
        stall = 6'b100111; ex_wd = 5'd17; ex_wreg = 1'b1; ex_wdata = 32'hCAFE_F00D;
        ex_whilo = 1'b1; ex_hi = 32'h0BAD_0001; ex_lo = 32'h0BAD_0002;
        step();
        chk("ign.wd",    64'(mem_wd),    64'd17);
        chk("ign.wdata", 64'(mem_wdata), 64'hCAFE_F00D);
        chk("ign.hi",    64'(mem_hi),    64'h0BAD_0001);
        chk("ign.lo",    64'(mem_lo),    64'h0BAD_0002);
        chk("ign.hilo",  hilo_o,         64'd0);

        // Flush beats a bubble stall and discards the pending partial
        stall = 6'b001111; hilo_i = 64'h0000_0001_FFFF_FFFE; cnt_i = 2'd1;
        step();
        chk("pre_flush.hilo", hilo_o, 64'h0000_0001_FFFF_FFFE);
        flush = 1'b1; hilo_i = 64'h5555_AAAA_5555_AAAA; cnt_i = 2'd2;
        step();
        chk_stage_zero("flush");
        chk("flush.hilo", hilo_o,     64'd0);
        chk("flush.cnt",  64'(cnt_o), 64'd0);

        // Flush also beats a full hold
        flush = 1'b0; stall = 6'd0; ex_wdata = 32'h0000_BEEF; ex_wd = 5'd3;
        step();
        chk("post_flush.wdata", 64'(mem_wdata), 64'h0000_BEEF);
        flush = 1'b1; stall = 6'b011111;
        step();
        chk("flush_hold.wdata", 64'(mem_wdata), 64'd0);
        chk("flush_hold.wd",    64'(mem_wd),    64'd0);

        // Mid-sequence asynchronous reset clears the partial without an edge
        flush = 1'b0; stall = 6'b001111; hilo_i = 64'hFEED; cnt_i = 2'd1;
        step();
        chk("pre_rst.hilo", hilo_o, 64'hFEED);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst.hilo", hilo_o,     64'd0);
        chk("mid_rst.cnt",  64'(cnt_o), 64'd0);
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
